branch_resolve_unit: RTL and testbench

- Next-generation branch unit: resolves conditional branches in execute and adds a parametrised direction predictor.
- Predictor is a table of 2-bit saturating counters, looked up at fetch and trained at resolve.
- Sits between the fetch PC generator (prediction port) and the execute stage (resolve port).
- Produces a registered resolve result (taken, target, mispredict, redirect PC) plus saturating performance counters.

---
 rtl/branch_resolve_unit.sv | 177 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves conditional branches and trains a 2-bit counter direction predictor.
// Latency: prediction is combinational; the resolve result is registered one cycle after ex_valid.
// Backpressure: none; accepts one branch per cycle, and flush drops the branch presented that cycle.

package branch_resolve_unit_pkg;

    // Encodings follow the RV32 branch funct3 field; 3'b010 and 3'b011 are unused.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_e;

endpackage

module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,   // power of two, at least 2
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,

    // fetch-side prediction port
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,

    // execute-side resolve port
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_imm,
    input  branch_e          ex_type,
    input  logic             ex_pred_taken,
    input  logic             flush,

    // registered resolve result
    output logic             res_valid,
    output logic             res_taken,
    output logic [XLEN-1:0]  res_target,
    output logic             res_mispredict,
    output logic [XLEN-1:0]  res_redirect_pc,
    output logic             res_misaligned,

    // performance counters
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Branch history table of 2-bit saturating counters; bit 1 is the prediction.
    logic [1:0]       bht [BHT_ENTRIES];

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] ex_idx;

    logic             br_known;     // ex_type is one of the six defined encodings
    logic             br_taken;     // actual outcome (0 for unknown encodings)
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  br_fallthru;
    logic [XLEN-1:0]  br_redirect;
    logic             br_mispredict;
    logic             br_misaligned;
    logic             accept;       // branch is live and will be resolved at this edge

    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_nxt;

    // Only the word-index bits of the fetch PC select a counter.
    logic             unused_pred_pc_bits;
    assign unused_pred_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign ex_idx   = ex_pc[IDX_W+1:2];

    // Table read is a plain array lookup, so a same-cycle update is not visible until the next cycle.
    assign pred_taken = bht[pred_idx][1];

    assign accept = ex_valid && !flush;

    // Evaluate the branch condition for the presented branch type.
    always_comb begin
        br_known = 1'b1;
        br_taken = 1'b0;
        case (ex_type)
            BR_BEQ:  br_taken = (ex_rs1 == ex_rs2);
            BR_BNE:  br_taken = (ex_rs1 != ex_rs2);
            BR_BLT:  br_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            BR_BGE:  br_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            BR_BLTU: br_taken = (ex_rs1 <  ex_rs2);
            BR_BGEU: br_taken = (ex_rs1 >= ex_rs2);
            default: begin
                br_known = 1'b0;
                br_taken = 1'b0;
            end
        endcase
    end

    // Target and fall-through both wrap modulo 2^XLEN; misalignment is reported but not corrected.
    always_comb begin
        br_target     = ex_pc + ex_imm;
        br_fallthru   = ex_pc + XLEN'(4);
        br_redirect   = br_taken ? br_target : br_fallthru;
        br_mispredict = br_known && (br_taken != ex_pred_taken);
        br_misaligned = br_taken && (br_target[1:0] != 2'b00);
    end

    // Saturating counter step toward the actual outcome.
    always_comb begin
        cnt_cur = bht[ex_idx];
        cnt_nxt = cnt_cur;
        if (br_taken) begin
            if (cnt_cur != 2'b11) begin
                cnt_nxt = cnt_cur + 2'd1;
            end
        end else begin
            if (cnt_cur != 2'b00) begin
                cnt_nxt = cnt_cur - 2'd1;
            end
        end
    end

    // Train the table on every accepted branch with a defined encoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept && br_known) begin
            bht[ex_idx] <= cnt_nxt;
        end
    end

    // Result register: valid pulses for one cycle, data holds until the next accepted branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_target      <= '0;
            res_mispredict  <= 1'b0;
            res_redirect_pc <= '0;
            res_misaligned  <= 1'b0;
        end else begin
            res_valid <= accept;
            if (accept) begin
                res_taken       <= br_taken;
                res_target      <= br_target;
                res_mispredict  <= br_mispredict;
                res_redirect_pc <= br_redirect;
                res_misaligned  <= br_misaligned;
            end
        end
    end

    // Performance counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (accept) begin
            if (perf_branches != {CNT_W{1'b1}}) begin
                perf_branches <= perf_branches + CNT_W'(1);
            end
            if (br_mispredict && (perf_mispredicts != {CNT_W{1'b1}})) begin
                perf_mispredicts <= perf_mispredicts + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
`timescale 1ns/1ps
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;   // narrow so counter saturation is reachable

    logic             clk;
    logic             rst;
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [XLEN-1:0]  ex_imm;
    branch_e          ex_type;
    logic             ex_pred_taken;
    logic             flush;
    logic             res_valid;
    logic             res_taken;
    logic [XLEN-1:0]  res_target;
    logic             res_mispredict;
    logic [XLEN-1:0]  res_redirect_pc;
    logic             res_misaligned;
    logic [CNT_W-1:0] perf_branches;
    logic [CNT_W-1:0] perf_mispredicts;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(64), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_imm           (ex_imm),
        .ex_type          (ex_type),
        .ex_pred_taken    (ex_pred_taken),
        .flush            (flush),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .res_mispredict   (res_mispredict),
        .res_redirect_pc  (res_redirect_pc),
        .res_misaligned   (res_misaligned),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic put(input branch_e t, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic pt);
        ex_valid      = 1'b1;
        ex_type       = t;
        ex_pc         = pc;
        ex_rs1        = r1;
        ex_rs2        = r2;
        ex_imm        = imm;
        ex_pred_taken = pt;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); pred_pc = 32'h100;
        ex_type = BR_BEQ; ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0; ex_pred_taken = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred: got %b want 0", pred_taken); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", res_valid); end
        checks++; if (res_target !== 32'h0) begin errors++; $display("FAIL rst_target: got %h want 0", res_target); end
        checks++; if (res_redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect: got %h want 0", res_redirect_pc); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid2: got %b want 0", res_valid); end
        checks++; if (perf_branches !== 5'd0) begin errors++; $display("FAIL rst_pbr: got %0d want 0", perf_branches); end
        checks++; if (perf_mispredicts !== 5'd0) begin errors++; $display("FAIL rst_pmis: got %0d want 0", perf_mispredicts); end
    endtask

    task automatic test_beq_taken();
        put(BR_BEQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
        @(negedge clk); idle();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL beq_valid: got %b want 1", res_valid); end
        checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", res_taken); end
        checks++; if (res_target !== 32'h120) begin errors++; $display("FAIL beq_target: got %h want 120", res_target); end
        checks++; if (res_redirect_pc !== 32'h120) begin errors++; $display("FAIL beq_redirect: got %h want 120", res_redirect_pc); end
        checks++; if (res_mispredict !== 1'b1) begin errors++; $display("FAIL beq_mis: got %b want 1", res_mispredict); end
        checks++; if (res_misaligned !== 1'b0) begin errors++; $display("FAIL beq_misal: got %b want 0", res_misaligned); end
        checks++; if (perf_branches !== 5'd1) begin errors++; $display("FAIL beq_pbr: got %0d want 1", perf_branches); end
        checks++; if (perf_mispredicts !== 5'd1) begin errors++; $display("FAIL beq_pmis: got %0d want 1", perf_mispredicts); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_pred: got %b want 1", pred_taken); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL beq_pulse: got %b want 0", res_valid); end
        checks++; if (res_target !== 32'h120) begin errors++; $display("FAIL beq_hold: got %h want 120", res_target); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3; i++) begin
            put(BR_BEQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1);
            @(negedge clk);
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d]: got %b want 1", i, res_valid); end
            checks++; if (res_mispredict !== 1'b0) begin errors++; $display("FAIL sat_mis[%0d]: got %b want 0", i, res_mispredict); end
        end
        checks++; if (perf_branches !== 5'd4) begin errors++; $display("FAIL sat_pbr: got %0d want 4", perf_branches); end
        put(BR_BNE, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1);
        @(negedge clk);
        checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL bne_taken: got %b want 0", res_taken); end
        checks++; if (res_mispredict !== 1'b1) begin errors++; $display("FAIL bne_mis: got %b want 1", res_mispredict); end
        checks++; if (res_redirect_pc !== 32'h104) begin errors++; $display("FAIL bne_redirect: got %h want 104", res_redirect_pc); end
        checks++; if (res_target !== 32'h120) begin errors++; $display("FAIL bne_target: got %h want 120", res_target); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL bne_pred1: got %b want 1", pred_taken); end
        put(BR_BNE, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1);
        @(negedge clk); idle();
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL bne_pred2: got %b want 0", pred_taken); end
        checks++; if (perf_branches !== 5'd6) begin errors++; $display("FAIL bne_pbr: got %0d want 6", perf_branches); end
        checks++; if (perf_mispredicts !== 5'd3) begin errors++; $display("FAIL bne_pmis: got %0d want 3", perf_mispredicts); end
    endtask

    task automatic test_signed_unsigned();
        put(BR_BLT, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0);
        @(negedge clk);
        checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL blt_taken: got %b want 1", res_taken); end
        checks++; if (res_target !== 32'h310) begin errors++; $display("FAIL blt_target: got %h want 310", res_target); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL blt_alias_pred: got %b want 1", pred_taken); end
        put(BR_BLTU, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0);
        @(negedge clk);
        checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL bltu_taken: got %b want 0", res_taken); end
        checks++; if (res_mispredict !== 1'b0) begin errors++; $display("FAIL bltu_mis: got %b want 0", res_mispredict); end
        checks++; if (res_redirect_pc !== 32'h304) begin errors++; $display("FAIL bltu_redirect: got %h want 304", res_redirect_pc); end
        put(BR_BGE, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0);
        @(negedge clk);
        checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL bge_taken: got %b want 0", res_taken); end
        put(BR_BGEU, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h6, 1'b1);
        @(negedge clk); idle();
        checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL bgeu_taken: got %b want 1", res_taken); end
        checks++; if (res_misaligned !== 1'b1) begin errors++; $display("FAIL bgeu_misal: got %b want 1", res_misaligned); end
        checks++; if (res_redirect_pc !== 32'h206) begin errors++; $display("FAIL bgeu_redirect: got %h want 206", res_redirect_pc); end
        checks++; if (res_mispredict !== 1'b0) begin errors++; $display("FAIL bgeu_mis: got %b want 0", res_mispredict); end
        checks++; if (perf_branches !== 5'd10) begin errors++; $display("FAIL su_pbr: got %0d want 10", perf_branches); end
        checks++; if (perf_mispredicts !== 5'd4) begin errors++; $display("FAIL su_pmis: got %0d want 4", perf_mispredicts); end
    endtask

    task automatic test_wrap();
        put(BR_BEQ, 32'h1FC, 32'd7, 32'd7, 32'h40, 1'b0);
        @(negedge clk);
        pred_pc = 32'h0FC;
        put(BR_BEQ, 32'hFFFF_FFFC, 32'd1, 32'd2, 32'h8, 1'b1);
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL wrap_nobypass: got %b want 1", pred_taken); end
        @(negedge clk); idle();
        checks++; if (res_redirect_pc !== 32'h0) begin errors++; $display("FAIL wrap_redirect: got %h want 0", res_redirect_pc); end
        checks++; if (res_target !== 32'h4) begin errors++; $display("FAIL wrap_target: got %h want 4", res_target); end
        checks++; if (res_mispredict !== 1'b1) begin errors++; $display("FAIL wrap_mis: got %b want 1", res_mispredict); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL wrap_pred_after: got %b want 0", pred_taken); end
        checks++; if (perf_mispredicts !== 5'd6) begin errors++; $display("FAIL wrap_pmis: got %0d want 6", perf_mispredicts); end
    endtask

    task automatic test_invalid_type();
        pred_pc = 32'h104;
        put(branch_e'(3'd2), 32'h104, 32'd9, 32'd9, 32'h10, 1'b1);
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL inv_valid: got %b want 1", res_valid); end
        checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL inv_taken: got %b want 0", res_taken); end
        checks++; if (res_mispredict !== 1'b0) begin errors++; $display("FAIL inv_mis: got %b want 0", res_mispredict); end
        checks++; if (res_redirect_pc !== 32'h108) begin errors++; $display("FAIL inv_redirect: got %h want 108", res_redirect_pc); end
        checks++; if (perf_branches !== 5'd13) begin errors++; $display("FAIL inv_pbr: got %0d want 13", perf_branches); end
        checks++; if (perf_mispredicts !== 5'd6) begin errors++; $display("FAIL inv_pmis: got %0d want 6", perf_mispredicts); end
        put(BR_BEQ, 32'h104, 32'd9, 32'd9, 32'h10, 1'b0);
        @(negedge clk); idle();
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL inv_noupdate: got %b want 1", pred_taken); end
        checks++; if (perf_mispredicts !== 5'd7) begin errors++; $display("FAIL inv_pmis2: got %0d want 7", perf_mispredicts); end
    endtask

    task automatic test_flush();
        pred_pc = 32'h108;
        put(BR_BEQ, 32'h108, 32'd3, 32'd3, 32'h40, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", res_valid); end
        checks++; if (perf_branches !== 5'd14) begin errors++; $display("FAIL fl_pbr: got %0d want 14", perf_branches); end
        checks++; if (perf_mispredicts !== 5'd7) begin errors++; $display("FAIL fl_pmis: got %0d want 7", perf_mispredicts); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL fl_table: got %b want 0", pred_taken); end
        checks++; if (res_target !== 32'h114) begin errors++; $display("FAIL fl_hold: got %h want 114", res_target); end
        flush = 1'b0;
        put(BR_BEQ, 32'h108, 32'd3, 32'd3, 32'h40, 1'b0);
        @(negedge clk);
        put(BR_BNE, 32'h108, 32'd3, 32'd3, 32'h40, 1'b1);
        flush = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL fl_noretract: got %b want 1", res_valid); end
        checks++; if (res_target !== 32'h148) begin errors++; $display("FAIL fl_target: got %h want 148", res_target); end
        @(negedge clk); idle();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL fl_valid2: got %b want 0", res_valid); end
        checks++; if (perf_branches !== 5'd15) begin errors++; $display("FAIL fl_pbr2: got %0d want 15", perf_branches); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL fl_table2: got %b want 1", pred_taken); end
    endtask

    task automatic test_reset_mid();
        pred_pc = 32'h104;
        put(BR_BEQ, 32'h104, 32'd1, 32'd1, 32'h10, 1'b0);
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b want 1", res_valid); end
        rst = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", res_valid); end
        checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL rm_taken: got %b want 0", res_taken); end
        checks++; if (res_target !== 32'h0) begin errors++; $display("FAIL rm_target: got %h want 0", res_target); end
        checks++; if (res_redirect_pc !== 32'h0) begin errors++; $display("FAIL rm_redirect: got %h want 0", res_redirect_pc); end
        checks++; if (perf_branches !== 5'd0) begin errors++; $display("FAIL rm_pbr: got %0d want 0", perf_branches); end
        checks++; if (perf_mispredicts !== 5'd0) begin errors++; $display("FAIL rm_pmis: got %0d want 0", perf_mispredicts); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rm_table: got %b want 0", pred_taken); end
        @(negedge clk);
        rst = 1'b0; idle();
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rm_lost: got %b want 0", res_valid); end
        checks++; if (perf_branches !== 5'd0) begin errors++; $display("FAIL rm_pbr2: got %0d want 0", perf_branches); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rm_table2: got %b want 0", pred_taken); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 35; i++) begin
            put(BR_BNE, 32'h100, 32'd1, 32'd2, 32'h20, 1'b0);
            @(negedge clk);
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, res_valid); end
            if (i == 30) begin
                checks++; if (perf_branches !== 5'd31) begin errors++; $display("FAIL b2b_pbr31: got %0d want 31", perf_branches); end
            end
        end
        idle();
        checks++; if (perf_branches !== 5'd31) begin errors++; $display("FAIL b2b_pbr_sat: got %0d want 31", perf_branches); end
        checks++; if (perf_mispredicts !== 5'd31) begin errors++; $display("FAIL b2b_pmis_sat: got %0d want 31", perf_mispredicts); end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_saturate();
        test_signed_unsigned();
        test_wrap();
        test_invalid_type();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
